// File: rtl/lsu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lsu_pkg : shared types and constants for the vector load/store unit  |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
package lsu_pkg;

  localparam int LANES = 6;

  typedef logic [2:0] lane_t;
  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ACCESS = 2'd1;
  localparam state_t ST_WAIT   = 2'd2;
  localparam state_t ST_RESP   = 2'd3;

endpackage
`default_nettype wire

// File: rtl/vector_lsu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vector_lsu : serialises scalar/6-lane requests into word RAM accesses|
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module vector_lsu
  import lsu_pkg::*;
#(
  parameter int S    = 32,
  parameter int V    = 192,
  parameter int SIZE = 30000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_we,
  input  logic         req_isVector,
  input  logic [S-1:0] req_addr,
  input  logic [V-1:0] req_wd,
  output logic         resp_valid,
  output logic         resp_err,
  output logic [V-1:0] resp_rd,
  output logic         stall,
  output logic         mem_we,
  output logic [S-1:0] mem_addr,
  output logic [S-1:0] mem_wd,
  input  logic [S-1:0] mem_rd
);

  state_t       state_q, state_d;
  lane_t        lane_q, lane_d;
  lane_t        cap_lane_q, cap_lane_d;
  logic         cap_q, cap_d;
  logic         we_q, we_d;
  logic         vec_q, vec_d;
  logic         err_q, err_d;
  logic [S-1:0] addr_q, addr_d;
  logic [V-1:0] wd_q, wd_d;
  logic [V-1:0] rd_q, rd_d;

  logic [S:0]   limit;
  logic         range_err;
  lane_t        last_lane;
  logic         in_access;

  // One extra bit keeps the comparison unsigned with no wrap at the top of the address space.
  assign limit     = (S+1)'(SIZE) - (req_isVector ? (S+1)'(LANES) : (S+1)'(1));
  assign range_err = {1'b0, req_addr} > limit;
  assign last_lane = vec_q ? lane_t'(LANES - 1) : lane_t'(0);
  assign in_access = (state_q == ST_ACCESS);

  always_comb begin
    state_d    = state_q;
    lane_d     = lane_q;
    we_d       = we_q;
    vec_d      = vec_q;
    err_d      = err_q;
    addr_d     = addr_q;
    wd_d       = wd_q;
    rd_d       = rd_q;
    cap_d      = in_access && !we_q;
    cap_lane_d = lane_q;
    // Read data trails the address by one cycle, so the slot index is the delayed lane.
    if (cap_q) begin
      rd_d[cap_lane_q*S +: S] = mem_rd;
    end
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d   = req_we;
          vec_d  = req_isVector;
          addr_d = req_addr;
          wd_d   = req_wd;
          lane_d = '0;
          err_d  = range_err;
          if (range_err) begin
            rd_d    = '0;
            state_d = ST_RESP;
          end else begin
            if (!req_we) begin
              rd_d = '0;
            end
            state_d = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        if (lane_q == last_lane) begin
          lane_d  = '0;
          state_d = we_q ? ST_RESP : ST_WAIT;
        end else begin
          lane_d = lane_q + lane_t'(1);
        end
      end
      ST_WAIT: state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      lane_q     <= '0;
      cap_lane_q <= '0;
      cap_q      <= 1'b0;
      we_q       <= 1'b0;
      vec_q      <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= '0;
      wd_q       <= '0;
      rd_q       <= '0;
    end else begin
      state_q    <= state_d;
      lane_q     <= lane_d;
      cap_lane_q <= cap_lane_d;
      cap_q      <= cap_d;
      we_q       <= we_d;
      vec_q      <= vec_d;
      err_q      <= err_d;
      addr_q     <= addr_d;
      wd_q       <= wd_d;
      rd_q       <= rd_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign stall      = req_valid & ~req_ready;
  assign resp_valid = (state_q == ST_RESP);
  assign resp_err   = resp_valid & err_q;
  assign resp_rd    = rd_q;
  assign mem_we     = in_access & we_q;
  assign mem_addr   = in_access ? (addr_q + S'(lane_q)) : '0;
  assign mem_wd     = mem_we ? wd_q[lane_q*S +: S] : '0;

endmodule
`default_nettype wire
